// File: rtl/mmio_io_ctrl_if.sv
// CPU-side io_* bus between the pipelined CPU (master) and the MMIO responder (slave).
// io_din is combinational from io_addr so the MEM stage sees data in the same cycle.
interface mmio_io_ctrl_if;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;

  modport master (
    output io_addr,
    output io_dout,
    output io_we,
    output io_rd,
    input  io_din
  );

  modport slave (
    input  io_addr,
    input  io_dout,
    input  io_we,
    input  io_rd,
    output io_din
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O responder: LED register, debounced button/switch capture,
// display register with a post-write hold, and a free-running cycle counter.
module mmio_io_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DISP_HOLD  = 8
) (
  input  logic               clk,
  input  logic               rst,
  mmio_io_ctrl_if.slave      bus,
  input  logic               btn,
  input  logic [15:0]        sw,
  output logic [15:0]        led,
  output logic [31:0]        disp
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HW = (DISP_HOLD  > 1) ? $clog2(DISP_HOLD)  : 1;

  localparam logic [5:0] A_LED     = 6'h00;
  localparam logic [5:0] A_IN_STAT = 6'h01;
  localparam logic [5:0] A_IN_DATA = 6'h02;
  localparam logic [5:0] A_OUT_ST  = 6'h03;
  localparam logic [5:0] A_DISP    = 6'h04;
  localparam logic [5:0] A_CYC     = 6'h05;

  logic [15:0]   r_led;
  logic [31:0]   r_disp;
  logic [31:0]   r_cyc;
  logic          r_btn_s1, r_btn_s2;
  logic [15:0]   r_sw_s1, r_sw_s2;
  logic          r_btn_db, r_btn_db_q;
  logic [DW-1:0] r_dcnt;
  logic [15:0]   r_sw_latch;
  logic          r_in_vld, r_ovr;
  logic          r_out_rdy;
  logic [HW-1:0] r_hcnt;

  logic [5:0]    w_word;
  logic          w_wr_led, w_wr_disp, w_rd_clr, w_press;
  logic          w_unused_addr;

  assign w_word        = bus.io_addr[7:2];
  assign w_unused_addr = ^bus.io_addr[1:0];
  assign w_wr_led      = bus.io_we && (w_word == A_LED);
  assign w_wr_disp     = bus.io_we && (w_word == A_DISP) && r_out_rdy;
  assign w_rd_clr      = bus.io_rd && (w_word == A_IN_DATA);
  assign w_press       = r_btn_db && !r_btn_db_q;

  assign led  = r_led;
  assign disp = r_disp;

  always_comb begin
    bus.io_din = 32'h0;
    case (w_word)
      A_LED:     bus.io_din = {16'h0, r_led};
      A_IN_STAT: bus.io_din = {30'h0, r_ovr, r_in_vld};
      A_IN_DATA: bus.io_din = {16'h0, r_sw_latch};
      A_OUT_ST:  bus.io_din = {31'h0, r_out_rdy};
      A_DISP:    bus.io_din = r_disp;
      A_CYC:     bus.io_din = r_cyc;
      default:   bus.io_din = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc <= 32'h0;
      r_led <= 16'h0;
    end else begin
      r_cyc <= r_cyc + 32'h1;
      if (w_wr_led) r_led <= bus.io_dout[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= 16'h0;
      r_sw_s2  <= 16'h0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // The debounced level only moves after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
      r_dcnt     <= '0;
    end else begin
      r_btn_db_q <= r_btn_db;
      if (r_btn_s2 == r_btn_db) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DW'(DEB_CYCLES - 1)) begin
        r_btn_db <= ~r_btn_db;
        r_dcnt   <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  // Handshakes: in_vld means sw_latch holds unread data; an 0x08 read with io_rd
  // consumes it. A press while in_vld is set is lost and flagged in ovr, unless that
  // same edge consumes the old data, in which case the press is captured normally.
  // out_rdy means a display write will be accepted; writes while low are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_latch <= 16'h0;
      r_in_vld   <= 1'b0;
      r_ovr      <= 1'b0;
    end else if (w_press) begin
      if (r_in_vld && !w_rd_clr) begin
        r_ovr <= 1'b1;
      end else begin
        r_sw_latch <= r_sw_s2;
        r_in_vld   <= 1'b1;
        r_ovr      <= 1'b0;
      end
    end else if (w_rd_clr) begin
      r_in_vld <= 1'b0;
      r_ovr    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp    <= 32'h0;
      r_out_rdy <= 1'b1;
      r_hcnt    <= '0;
    end else if (w_wr_disp) begin
      r_disp    <= bus.io_dout;
      r_out_rdy <= 1'b0;
      r_hcnt    <= HW'(DISP_HOLD - 1);
    end else if (!r_out_rdy) begin
      if (r_hcnt == '0) r_out_rdy <= 1'b1;
      else              r_hcnt    <= r_hcnt - HW'(1);
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with DEB_CYCLES=4 and DISP_HOLD=8.
// Inputs change on the falling edge; combinational reads are sampled shortly after.
module tb_mmio_io_ctrl;
  logic        clk;
  logic        rst;
  logic        btn;
  logic [15:0] sw;
  logic [15:0] led;
  logic [31:0] disp;
  int          n_checks;
  int          n_fail;
  logic [31:0] rd_v;

  mmio_io_ctrl_if bus ();

  mmio_io_ctrl #(.DEB_CYCLES(4), .DISP_HOLD(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .btn  (btn),
    .sw   (sw),
    .led  (led),
    .disp (disp)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.io_addr = a;
    #1;
    check_eq(tag, bus.io_din, exp);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.io_addr = a;
    bus.io_dout = d;
    bus.io_we   = 1'b1;
    tick();
    bus.io_we   = 1'b0;
  endtask

  // Full press then release, long enough for both debounced edges.
  task automatic press(input logic [15:0] s);
    sw  = s;
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    btn         = 1'b0;
    sw          = 16'h0;
    bus.io_addr = 8'h0;
    bus.io_dout = 32'h0;
    bus.io_we   = 1'b0;
    bus.io_rd   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_led", {16'h0, led}, 32'h0);
    check_eq("rst_disp", disp, 32'h0);
    rd_chk("rst_r00", 8'h00, 32'h0);
    rd_chk("rst_r04", 8'h04, 32'h0);
    rd_chk("rst_r0c", 8'h0C, 32'h1);
    rd_chk("rst_r14", 8'h14, 32'h0);
    repeat (10) tick();
    rd_chk("cyc_10", 8'h14, 32'd10);

    // Counter wrap
    force dut.r_cyc = 32'hFFFF_FFFF;
    rd_chk("cyc_max", 8'h14, 32'hFFFF_FFFF);
    #2 release dut.r_cyc;
    tick();
    rd_chk("cyc_wrap", 8'h14, 32'h0);

    // LED writes and unmapped address
    bus_write(8'h00, 32'hDEAD_BEEF);
    check_eq("led_pin", {16'h0, led}, 32'h0000_BEEF);
    rd_chk("led_r00", 8'h00, 32'h0000_BEEF);
    bus_write(8'h20, 32'h0000_1234);
    check_eq("unmap_led", {16'h0, led}, 32'h0000_BEEF);
    check_eq("unmap_disp", disp, 32'h0);
    rd_chk("unmap_r20", 8'h20, 32'h0);
    rd_chk("unmap_r0c", 8'h0C, 32'h1);
    bus_write(8'h03, 32'h0000_0101);
    check_eq("addr_lo_ign", {16'h0, led}, 32'h0000_0101);

    // Write and read together: read sees pre-write data
    bus.io_addr = 8'h00;
    bus.io_dout = 32'h0000_5555;
    bus.io_we   = 1'b1;
    bus.io_rd   = 1'b1;
    #1 check_eq("wr_rd_old", bus.io_din, 32'h0000_0101);
    tick();
    bus.io_we = 1'b0;
    bus.io_rd = 1'b0;
    rd_chk("wr_rd_new", 8'h00, 32'h0000_5555);

    // Press latency: btn set before edge k, in_vld visible after edge k+6
    sw  = 16'h00A5;
    btn = 1'b1;
    bus.io_addr = 8'h04;
    repeat (6) tick();
    rd_chk("press_k5", 8'h04, 32'h0);
    tick();
    rd_chk("press_k6", 8'h04, 32'h1);
    repeat (3) tick();
    btn = 1'b0;
    repeat (10) tick();
    rd_chk("press_once", 8'h04, 32'h1);
    bus.io_rd = 1'b1;
    rd_chk("data_a5", 8'h08, 32'h0000_00A5);
    tick();
    bus.io_rd = 1'b0;
    rd_chk("clr_r04", 8'h04, 32'h0);
    rd_chk("latch_keep", 8'h08, 32'h0000_00A5);

    // Glitch of DEB_CYCLES-1 cycles
    sw  = 16'h00FF;
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (12) tick();
    rd_chk("glitch_r04", 8'h04, 32'h0);
    rd_chk("glitch_r08", 8'h08, 32'h0000_00A5);

    // Overrun
    press(16'h00A5);
    press(16'h005A);
    rd_chk("ovr_r04", 8'h04, 32'h3);
    rd_chk("ovr_r08", 8'h08, 32'h0000_00A5);
    bus.io_rd = 1'b1;
    rd_chk("ovr_rd", 8'h08, 32'h0000_00A5);
    tick();
    bus.io_rd = 1'b0;
    rd_chk("ovr_clr", 8'h04, 32'h0);

    // Display hold
    bus_write(8'h10, 32'h0000_0011);
    check_eq("disp_11", disp, 32'h0000_0011);
    rd_chk("disp_r10", 8'h10, 32'h0000_0011);
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("hold_%0d", i), 8'h0C, 32'h0);
      if (i == 2) begin
        bus.io_addr = 8'h10;
        bus.io_dout = 32'h0000_0022;
        bus.io_we   = 1'b1;
      end
      tick();
      bus.io_we = 1'b0;
    end
    rd_chk("hold_end", 8'h0C, 32'h1);
    check_eq("disp_ign22", disp, 32'h0000_0011);
    bus_write(8'h10, 32'h0000_0033);
    check_eq("disp_33", disp, 32'h0000_0033);
    rd_chk("rdy_33", 8'h0C, 32'h0);

    // Press coincident with consuming read: old data returned, event wins
    press(16'h0077);
    rd_chk("pre_vld", 8'h04, 32'h1);
    sw  = 16'h003C;
    btn = 1'b1;
    repeat (6) tick();
    bus.io_addr = 8'h08;
    bus.io_rd   = 1'b1;
    #1 check_eq("coinc_old", bus.io_din, 32'h0000_0077);
    tick();
    bus.io_rd = 1'b0;
    rd_chk("coinc_r04", 8'h04, 32'h1);
    rd_chk("coinc_r08", 8'h08, 32'h0000_003C);
    btn = 1'b0;
    repeat (10) tick();

    // Reset mid-debounce and mid-hold
    bus_write(8'h10, 32'h0000_0044);
    sw  = 16'h1111;
    btn = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    btn = 1'b0;
    #1;
    check_eq("arst_led", {16'h0, led}, 32'h0);
    check_eq("arst_disp", disp, 32'h0);
    rd_chk("arst_r04", 8'h04, 32'h0);
    rd_chk("arst_r08", 8'h08, 32'h0);
    rd_chk("arst_r0c", 8'h0C, 32'h1);
    rd_chk("arst_r14", 8'h14, 32'h0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    rd_chk("arst_noevt", 8'h04, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
